// File: rtl/rsa_io_pkg.sv
// Shared widths and FSM encodings for the BRAM <-> AXI-stream adapter.
// The 1024-bit chunk is carried as two 512-bit halves; word k always lives at bits [64k +: 64].
package rsa_io_pkg;
   localparam int WORD_W  = 64;
   localparam int BEATS   = 16;
   localparam int CHUNK_W = 1024;
   localparam int HALF_W  = CHUNK_W / 2;
   localparam int CNT_W   = $clog2(BEATS);

   typedef enum logic {
      IN_COLLECT = 1'b0,
      IN_DONE    = 1'b1
   } in_state_t;

   typedef enum logic {
      OUT_IDLE   = 1'b0,
      OUT_STREAM = 1'b1
   } out_state_t;
endpackage

// File: rtl/chunk_serializer.sv
// Captures a 1024-bit result from the two cores into a shadow register and streams it
// out as BEATS words, low half first, with m_tlast on the final word.
module chunk_serializer #(
   parameter int WORD_W = rsa_io_pkg::WORD_W,
   parameter int BEATS  = rsa_io_pkg::BEATS
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [WORD_W*BEATS/2-1:0]   bram_dout1,
   input  logic [WORD_W*BEATS/2-1:0]   bram_dout2,
   input  logic                        bram_dout1_valid,
   input  logic                        bram_dout2_valid,
   output logic                        bram_dout_read,
   output logic [WORD_W-1:0]           m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast
);
   import rsa_io_pkg::*;

   localparam int CW = WORD_W * BEATS;
   localparam int CW_CNT = $clog2(BEATS);
   localparam logic [CW_CNT-1:0] LAST_CNT = CW_CNT'(BEATS - 1);

   out_state_t        state_q, state_d;
   logic [CW_CNT-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0]     shadow_q, shadow_d;
   logic              armed_q, armed_d;
   logic              read_q, read_d;
   logic              both_valid;

   assign both_valid = bram_dout1_valid & bram_dout2_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= OUT_IDLE;
         out_cnt_q <= '0;
         shadow_q  <= '0;
         armed_q   <= 1'b0;
         read_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_cnt_q <= out_cnt_d;
         shadow_q  <= shadow_d;
         armed_q   <= armed_d;
         read_q    <= read_d;
      end
   end

   // A result is only taken after valid has been seen low, so a core that holds
   // valid high after we finish streaming is not read twice.
   always_comb begin
      state_d   = state_q;
      out_cnt_d = out_cnt_q;
      shadow_d  = shadow_q;
      armed_d   = armed_q;
      read_d    = 1'b0;
      case (state_q)
         OUT_IDLE: begin
            if (!both_valid) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               shadow_d = {bram_dout2, bram_dout1};
               armed_d  = 1'b0;
               read_d   = 1'b1;
               state_d  = OUT_STREAM;
            end
         end
         OUT_STREAM: begin
            if (m_tready) begin
               if (out_cnt_q == LAST_CNT) begin
                  out_cnt_d = '0;
                  state_d   = OUT_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = OUT_IDLE;
      endcase
   end

   assign bram_dout_read = read_q;
   assign m_tvalid       = (state_q == OUT_STREAM);
   assign m_tdata        = m_tvalid ? shadow_q[out_cnt_q*WORD_W +: WORD_W] : '0;
   assign m_tlast        = m_tvalid & (out_cnt_q == LAST_CNT);
endmodule

// File: rtl/bram_stream_adapter.sv
// Assembles BEATS stream words into a 1024-bit BRAM chunk and hands core results back
// out as a word stream; the two directions share nothing but clock and reset.
module bram_stream_adapter #(
   parameter int WORD_W = rsa_io_pkg::WORD_W,
   parameter int BEATS  = rsa_io_pkg::BEATS
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [WORD_W-1:0]           s_tdata,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   output logic [WORD_W*BEATS/2-1:0]   bram_din1,
   output logic [WORD_W*BEATS/2-1:0]   bram_din2,
   output logic                        bram_din_valid,
   input  logic [WORD_W*BEATS/2-1:0]   bram_dout1,
   input  logic [WORD_W*BEATS/2-1:0]   bram_dout2,
   input  logic                        bram_dout1_valid,
   input  logic                        bram_dout2_valid,
   output logic                        bram_dout_read,
   output logic [WORD_W-1:0]           m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast
);
   import rsa_io_pkg::*;

   localparam int CW = WORD_W * BEATS;
   localparam int HW = CW / 2;
   localparam int IN_CNT_W = $clog2(BEATS);
   localparam logic [IN_CNT_W-1:0] LAST_CNT = IN_CNT_W'(BEATS - 1);

   in_state_t           in_state_q, in_state_d;
   logic [IN_CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0]       din_q, din_d;
   logic                beat_acc;

   // Gating with resetn keeps the DMA from seeing ready while the adapter is held in reset.
   assign s_tready = resetn & (in_state_q == IN_COLLECT);
   assign beat_acc = s_tvalid & s_tready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_state_q <= IN_COLLECT;
         in_cnt_q   <= '0;
         din_q      <= '0;
      end else begin
         in_state_q <= in_state_d;
         in_cnt_q   <= in_cnt_d;
         din_q      <= din_d;
      end
   end

   always_comb begin
      in_state_d = in_state_q;
      in_cnt_d   = in_cnt_q;
      din_d      = din_q;
      case (in_state_q)
         IN_COLLECT: begin
            if (beat_acc) begin
               din_d[in_cnt_q*WORD_W +: WORD_W] = s_tdata;
               if (in_cnt_q == LAST_CNT) begin
                  in_cnt_d   = '0;
                  in_state_d = IN_DONE;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         IN_DONE:  in_state_d = IN_COLLECT;
         default:  in_state_d = IN_COLLECT;
      endcase
   end

   assign bram_din1      = din_q[HW-1:0];
   assign bram_din2      = din_q[CW-1:HW];
   assign bram_din_valid = (in_state_q == IN_DONE);

   chunk_serializer #(
      .WORD_W (WORD_W),
      .BEATS  (BEATS)
   ) u_serializer (
      .clk              (clk),
      .resetn           (resetn),
      .bram_dout1       (bram_dout1),
      .bram_dout2       (bram_dout2),
      .bram_dout1_valid (bram_dout1_valid),
      .bram_dout2_valid (bram_dout2_valid),
      .bram_dout_read   (bram_dout_read),
      .m_tdata          (m_tdata),
      .m_tvalid         (m_tvalid),
      .m_tready         (m_tready),
      .m_tlast          (m_tlast)
   );
endmodule

// File: tb/tb_bram_stream_adapter.sv
// Self-checking bench for bram_stream_adapter: scoreboard queues hold expected chunks
// and output words, pushed as stimulus is driven and popped as the DUT produces them.
module tb_bram_stream_adapter;
   logic          clk = 1'b0;
   logic          resetn;
   logic [63:0]   s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [511:0]  bram_din1, bram_din2;
   logic          bram_din_valid;
   logic [511:0]  bram_dout1, bram_dout2;
   logic          bram_dout1_valid, bram_dout2_valid;
   logic          bram_dout_read;
   logic [63:0]   m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;

   int checks   = 0;
   int failures = 0;

   logic [1023:0] exp_in_q[$];
   logic [63:0]   exp_out_q[$];

   always #5 clk = ~clk;

   bram_stream_adapter dut (
      .clk              (clk),
      .resetn           (resetn),
      .s_tdata          (s_tdata),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .bram_din1        (bram_din1),
      .bram_din2        (bram_din2),
      .bram_din_valid   (bram_din_valid),
      .bram_dout1       (bram_dout1),
      .bram_dout2       (bram_dout2),
      .bram_dout1_valid (bram_dout1_valid),
      .bram_dout2_valid (bram_dout2_valid),
      .bram_dout_read   (bram_dout_read),
      .m_tdata          (m_tdata),
      .m_tvalid         (m_tvalid),
      .m_tready         (m_tready),
      .m_tlast          (m_tlast)
   );

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Tasks start and end 1 time unit after a rising edge; outputs are sampled 4 units later.
   task automatic test_reset();
      resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
      bram_dout1 = '0; bram_dout2 = '0; bram_dout1_valid = 1'b0; bram_dout2_valid = 1'b0;
      m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #4;
      checks++;
      if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready got=%0b exp=0", s_tready); end
      checks++;
      if ({bram_din2, bram_din1} !== 1024'h0) begin failures++; $display("FAIL reset_din got_nonzero exp=0"); end
      checks++;
      if ({bram_din_valid, bram_dout_read, m_tvalid, m_tlast} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {bram_din_valid, bram_dout_read, m_tvalid, m_tlast});
      end
      checks++;
      if (m_tdata !== 64'h0) begin failures++; $display("FAIL reset_m_tdata got=%h exp=0", m_tdata); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_release_s_tready got=%0b exp=1", s_tready); end
      $display("reset: released, s_tready=%0b", s_tready);
   endtask

   task automatic test_input(input bit toggle);
      logic [1023:0] exp_chunk;
      logic [1023:0] e;
      int beats = 0, pulses = 0, last_acc = -100, pulse_cyc = -1, c = 0;
      for (int k = 0; k < 16; k++) exp_chunk[k*64 +: 64] = 64'(k + 1);
      while (c < 80 && !(beats == 16 && c > last_acc + 3)) begin
         s_tvalid = (beats < 16) && (!toggle || (c % 2 == 0));
         s_tdata  = 64'(beats + 1);
         #4;
         if (bram_din_valid) begin
            pulses++;
            pulse_cyc = c;
            checks++;
            if (c != last_acc + 1) begin failures++; $display("FAIL din_valid_timing got_cycle=%0d exp_cycle=%0d", c, last_acc + 1); end
            checks++;
            if (s_tready !== 1'b0) begin failures++; $display("FAIL done_s_tready got=%0b exp=0", s_tready); end
            checks++;
            if (exp_in_q.size() == 0) begin
               failures++; $display("FAIL din_unexpected_pulse got=1 exp=0 cycle=%0d", c);
            end else begin
               e = exp_in_q.pop_front();
               if ({bram_din2, bram_din1} !== e) begin
                  failures++; $display("FAIL din_chunk got_lo=%h got_hi=%h exp_lo=%h exp_hi=%h", bram_din1[63:0], bram_din2[511:448], e[63:0], e[1023:960]);
               end
            end
            checks++;
            if (bram_din1[63:0] !== 64'd1 || bram_din2[511:448] !== 64'd16) begin
               failures++; $display("FAIL din_lanes got=%h/%h exp=1/10", bram_din1[63:0], bram_din2[511:448]);
            end
            $display("input chunk: toggle=%0b pulse_cycle=%0d din1[63:0]=%h din2[511:448]=%h", toggle, c, bram_din1[63:0], bram_din2[511:448]);
         end
         if (s_tvalid && s_tready) begin
            beats++;
            if (beats == 16) begin exp_in_q.push_back(exp_chunk); last_acc = c; end
         end
         @(posedge clk); #1;
         c++;
      end
      s_tvalid = 1'b0;
      checks++;
      if (beats != 16) begin failures++; $display("FAIL input_timeout got_beats=%0d exp=16", beats); end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL din_pulse_count got=%0d exp=1", pulses); end
      if (!toggle) begin
         checks++;
         if (pulse_cyc != 16) begin failures++; $display("FAIL din_burst_cycle got=%0d exp=16", pulse_cyc); end
      end
      checks++;
      if (exp_in_q.size() != 0) begin failures++; $display("FAIL din_missing got_pending=%0d exp=0", exp_in_q.size()); exp_in_q.delete(); end
   endtask

   task automatic test_output(input logic [511:0] d1, input logic [511:0] d2, input bit stall, input int partial);
      int got = 0, reads = 0, c = 0, extra = 0, first_valid = -1, read_cyc = -1;
      logic [63:0] prev_data = '0;
      logic [63:0] w;
      bit prev_stall = 1'b0;
      bram_dout1 = d1; bram_dout2 = d2; m_tready = 1'b1;
      bram_dout1_valid = 1'b1; bram_dout2_valid = 1'b0;
      for (int i = 0; i < partial; i++) begin
         #4;
         checks++;
         if (bram_dout_read !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++; $display("FAIL partial_valid_wait cycle=%0d got_read=%0b got_tvalid=%0b exp=0/0", i, bram_dout_read, m_tvalid);
         end
         @(posedge clk); #1;
      end
      bram_dout2_valid = 1'b1;
      for (int k = 0; k < 16; k++) exp_out_q.push_back(k < 8 ? d1[k*64 +: 64] : d2[(k-8)*64 +: 64]);
      while (c < 300 && extra < 10) begin
         m_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         #4;
         if (bram_dout_read) begin reads++; if (read_cyc < 0) read_cyc = c; end
         if (m_tvalid && first_valid < 0) first_valid = c;
         if (prev_stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
               failures++; $display("FAIL stall_hold got=%h/%0b exp=%h/1", m_tdata, m_tvalid, prev_data);
            end
         end
         if (m_tvalid) begin
            checks++;
            if (m_tlast !== (got == 15)) begin failures++; $display("FAIL m_tlast word=%0d got=%0b exp=%0b", got, m_tlast, got == 15); end
            if (m_tready) begin
               checks++;
               if (exp_out_q.size() == 0) begin
                  failures++; $display("FAIL m_extra_word got=%h exp=none", m_tdata);
               end else begin
                  w = exp_out_q.pop_front();
                  if (m_tdata !== w) begin failures++; $display("FAIL m_word%0d got=%h exp=%h", got, m_tdata, w); end
               end
               $display("output word %0d: data=%h last=%0b", got, m_tdata, m_tlast);
               got++;
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         if (got >= 16) extra++;
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (got != 16) begin failures++; $display("FAIL out_word_count got=%0d exp=16", got); end
      checks++;
      if (reads != 1) begin failures++; $display("FAIL dout_read_count got=%0d exp=1", reads); end
      checks++;
      if (read_cyc != first_valid) begin failures++; $display("FAIL dout_read_cycle got=%0d exp=%0d", read_cyc, first_valid); end
      checks++;
      if (m_tvalid !== 1'b0) begin failures++; $display("FAIL recapture_while_valid got=%0b exp=0", m_tvalid); end
      checks++;
      if (exp_out_q.size() != 0) begin failures++; $display("FAIL out_missing got_pending=%0d exp=0", exp_out_q.size()); exp_out_q.delete(); end
      bram_dout1_valid = 1'b0; bram_dout2_valid = 1'b0; m_tready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bram_dout1 = '1; bram_dout2 = '1; m_tready = 1'b0;
      bram_dout1_valid = 1'b1; bram_dout2_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         s_tvalid = 1'b1; s_tdata = 64'(16'hF00 + i);
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      #4;
      checks++;
      if (m_tvalid !== 1'b1) begin failures++; $display("FAIL mid_stream_active got=%0b exp=1", m_tvalid); end
      resetn = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || {bram_din2, bram_din1} !== 1024'h0) begin
         failures++; $display("FAIL async_reset got_tvalid=%0b got_tready=%0b exp=0/0 din_zero", m_tvalid, s_tready);
      end
      bram_dout1_valid = 1'b0; bram_dout2_valid = 1'b0;
      @(posedge clk); #1;
      #4;
      checks++;
      if (bram_din_valid !== 1'b0 || m_tlast !== 1'b0) begin
         failures++; $display("FAIL reset_spurious got=%0b/%0b exp=0/0", bram_din_valid, m_tlast);
      end
      @(posedge clk); #1;
      m_tready = 1'b1;
      resetn = 1'b1;
      $display("mid-chunk reset: released after 7 beats");
      test_input(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_input(1'b0);
      test_input(1'b1);
      test_output(512'h1, {448'h0, 64'hA5}, 1'b0, 0);
      test_output(rand512(), rand512(), 1'b1, 0);
      test_output(rand512(), rand512(), 1'b0, 10);
      fork
         test_input(1'b0);
         test_output(rand512(), rand512(), 1'b1, 0);
      join
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_stream_adapter.md
BRAM_STREAM_ADAPTER -- requirements
Module: bram_stream_adapter

Interface
REQ-001 SHALL have parameters: WORD_W, default 64, stream word width; BEATS, default 16, words per 1024-bit chunk (BEATS*WORD_W = 1024).
REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk, in, 1, single clock; all logic rising-edge.
  - resetn, in, 1, asynchronous active-low reset.
  - s_tdata, in, 64, DMA word in.
  - s_tvalid, in, 1, s_tdata valid.
  - s_tready, out, 1, adapter accepts word.
  - bram_din1, out, 512, assembled low half.
  - bram_din2, out, 512, assembled high half.
  - bram_din_valid, out, 1, chunk complete pulse.
  - bram_dout1, in, 512, core-1 result.
  - bram_dout2, in, 512, core-2 result.
  - bram_dout1_valid, in, 1, core-1 result valid.
  - bram_dout2_valid, in, 1, core-2 result valid.
  - bram_dout_read, out, 1, result captured pulse.
  - m_tdata, out, 64, result word out.
  - m_tvalid, out, 1, m_tdata valid.
  - m_tready, in, 1, sink accepts word.
  - m_tlast, out, 1, final word of chunk.

Function
REQ-003 Input FSM SHALL have states IN_COLLECT and IN_DONE; s_tready SHALL be 1 exactly in IN_COLLECT.
REQ-004 A beat SHALL be accepted when s_tvalid & s_tready; a 4-bit in_cnt SHALL increment per beat.
REQ-005 Beat k (0..7) SHALL be written to bram_din1[64k+63:64k]; beat k (8..15) SHALL be written to bram_din2[64(k-8)+63:64(k-8)].
REQ-006 On acceptance of beat 15, in_cnt SHALL wrap to 0 and the FSM SHALL enter IN_DONE.
REQ-007 IN_DONE SHALL last exactly one cycle, with bram_din_valid=1, and SHALL then return to IN_COLLECT.
REQ-008 bram_din_valid SHALL be 0 in all other cycles.
REQ-009 bram_din1/2 SHALL hold their value except for the lane written by an accepted beat.
REQ-010 Chunk latency: bram_din_valid SHALL rise one cycle after beat 15 is accepted.
REQ-011 Output FSM SHALL have states OUT_IDLE and OUT_STREAM.
REQ-012 In OUT_IDLE, an armed flag SHALL be set in any cycle where bram_dout1_valid & bram_dout2_valid is 0.
REQ-013 A capture SHALL occur in OUT_IDLE when armed & bram_dout1_valid & bram_dout2_valid.
REQ-014 On capture: {bram_dout2, bram_dout1} SHALL be copied to a 1024-bit shadow register, armed SHALL clear, bram_dout_read SHALL be 1 for exactly the next cycle, and the FSM SHALL enter OUT_STREAM.
REQ-015 If only one of bram_dout1_valid/bram_dout2_valid is high, the adapter SHALL wait; no capture and no bram_dout_read.
REQ-016 In OUT_STREAM, m_tvalid SHALL be 1 and m_tdata SHALL be shadow word out_cnt, using the same lane ordering as REQ-005.
REQ-017 out_cnt SHALL advance only when m_tvalid & m_tready; m_tdata SHALL stay stable while m_tready=0.
REQ-018 m_tlast SHALL be 1 only when out_cnt=15.
REQ-019 After word 15 is accepted, the FSM SHALL return to OUT_IDLE with m_tvalid=0 and out_cnt=0.
REQ-020 bram_dout*_valid SHALL be ignored during OUT_STREAM.
REQ-021 The input and output paths SHALL be fully independent; simultaneous input beats and output beats SHALL both proceed.
REQ-022 The first capture after reset SHALL require valid to have been seen low at least once (armed starts 0).

Reset
REQ-023 When resetn=0, asynchronously: both FSMs SHALL go to IN_COLLECT/OUT_IDLE; counters, armed, and shadow SHALL be 0.
REQ-024 During reset, outputs SHALL be: bram_din1/2=0, bram_din_valid=0, bram_dout_read=0, m_tvalid=0, m_tlast=0, m_tdata=0.
REQ-025 s_tready SHALL be 0 while resetn=0 and SHALL be 1 on the first clock after release.
REQ-026 Reset mid-chunk or mid-stream SHALL discard partial data; no bram_din_valid or m_tlast SHALL be produced for it.

Structure
REQ-027 Shared package rsa_io_pkg SHALL hold WORD_W, BEATS, CHUNK_W=1024, and the IN_*/OUT_* state encodings.
REQ-028 The output path SHALL be a sub-module chunk_serializer (shadow register, out_cnt, OUT FSM); the input assembly SHALL stay in the top.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
  - Send 16 beats, value i+1, s_tvalid held high: bram_din_valid pulses once, at cycle 17; bram_din1[63:0]=1; bram_din2[511:448]=16; s_tready=0 in that cycle.
  - Send the same chunk with s_tvalid toggling 1/0: identical data; valid pulse one cycle after the 16th accepted beat.
  - bram_dout1=512'h1, bram_dout2={448'h0,64'hA5}, both valid held high: one bram_dout_read pulse, then 16 words; word0=1, word8=0xA5, m_tlast on word15.
  - Random m_tready stalls: no word lost or duplicated; m_tdata stable while stalled; valid still high after the stream gives no second capture until valid drops.
  - bram_dout1_valid=1 with bram_dout2_valid=0 for 10 cycles: no bram_dout_read and m_tvalid=0; capture occurs once both are high.
  - Assert resetn=0 after 7 input beats: the next 16 beats produce one correct chunk; no spurious pulse.
